// File: rtl/dmem_port_arbiter.sv
// Shares one data-cache port between ROB commit stores and load-buffer loads.
// Requests are captured at grant, so the cache sees stable values for the whole transaction.
module dmem_port_arbiter #(
  parameter bit STORE_FIRST = 1'b1,
  parameter int WDOG_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rob_mem_write,
  input  logic [31:0] rob_mem_address,
  input  logic [31:0] rob_mem_wdata,
  input  logic [3:0]  rob_mem_byte_enable,
  output logic        rob_mem_resp,
  input  logic        ld_mem_read,
  input  logic [31:0] ld_mem_address,
  output logic        ld_mem_resp,
  output logic [31:0] ld_mem_rdata,
  input  logic        flush,
  output logic        dc_mem_read,
  output logic        dc_mem_write,
  output logic [31:0] dc_mem_address,
  output logic [31:0] dc_mem_wdata,
  output logic [3:0]  dc_mem_byte_enable,
  input  logic        dc_mem_resp,
  input  logic [31:0] dc_mem_rdata,
  output logic        mem_hang
);

  // state      | meaning
  // IDLE       | no cache transaction; grants a pending request
  // STORE      | committed store in flight, runs to completion
  // LOAD       | load in flight, response forwarded to the load buffer
  // LOAD_DRAIN | load flushed, waits out the cache response silently
  typedef enum logic [1:0] {IDLE, STORE, LOAD, LOAD_DRAIN} state_t;

  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES);

  state_t state, state_next;
  logic ld_ok, grant_store, grant_load;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] be_q;
  logic [WDOG_W-1:0] wdog_cnt, wdog_inc;
  logic ld_addr_unused;

  // The cache is word-addressed for loads; the byte offset is the load buffer's business.
  assign ld_addr_unused = ^ld_mem_address[1:0];

  always_comb begin
    ld_ok = ld_mem_read && !flush;
    grant_store = 1'b0;
    grant_load = 1'b0;
    if (state == IDLE) begin
      if (rob_mem_write && (STORE_FIRST || !ld_ok)) grant_store = 1'b1;
      else if (ld_ok) grant_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_store) state_next = STORE;
        else if (grant_load) state_next = LOAD;
      end
      STORE: if (dc_mem_resp) state_next = IDLE;
      LOAD: begin
        if (dc_mem_resp) state_next = IDLE;
        else if (flush) state_next = LOAD_DRAIN;
      end
      LOAD_DRAIN: if (dc_mem_resp) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dc_mem_read = 1'b0;
    dc_mem_write = 1'b0;
    rob_mem_resp = 1'b0;
    ld_mem_resp = 1'b0;
    ld_mem_rdata = '0;
    case (state)
      STORE: begin
        dc_mem_write = 1'b1;
        rob_mem_resp = dc_mem_resp;
      end
      LOAD: begin
        dc_mem_read = 1'b1;
        ld_mem_resp = dc_mem_resp && !flush;
      end
      LOAD_DRAIN: dc_mem_read = 1'b1;
      default: ;
    endcase
    if (ld_mem_resp) ld_mem_rdata = dc_mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
    end else if (grant_store) begin
      addr_q <= rob_mem_address;
      wdata_q <= rob_mem_wdata;
      be_q <= rob_mem_byte_enable;
    end else if (grant_load) begin
      addr_q <= {ld_mem_address[31:2], 2'b00};
      wdata_q <= '0;
      be_q <= 4'b1111;
    end
  end

  assign dc_mem_address = addr_q;
  assign dc_mem_wdata = wdata_q;
  assign dc_mem_byte_enable = be_q;

  assign wdog_inc = (&wdog_cnt) ? wdog_cnt : wdog_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
      mem_hang <= 1'b0;
    end else begin
      if (grant_store || grant_load) wdog_cnt <= '0;
      else if (state != IDLE) wdog_cnt <= wdog_inc;
      if (state != IDLE && wdog_inc == WDOG_MAX) mem_hang <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized scoreboard bench for dmem_port_arbiter plus directed priority, flush and watchdog cases.
// A second instance with load priority covers the opposite tie-break.
module tb_dmem_port_arbiter;
  localparam bit SF0 = 1'b1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic rob_mem_write, rob_mem_resp, ld_mem_read, ld_mem_resp, flush;
  logic [31:0] rob_mem_address, rob_mem_wdata, ld_mem_address, ld_mem_rdata;
  logic [3:0] rob_mem_byte_enable, dc_mem_byte_enable;
  logic dc_mem_read, dc_mem_write, dc_mem_resp, mem_hang;
  logic [31:0] dc_mem_address, dc_mem_wdata, dc_mem_rdata;

  logic b_rob_write, b_rob_resp, b_ld_read, b_ld_resp, b_flush;
  logic [31:0] b_rob_addr, b_rob_wdata, b_ld_addr, b_ld_rdata;
  logic [3:0] b_rob_be, b_dc_be;
  logic b_dc_read, b_dc_write, b_dc_resp, b_hang;
  logic [31:0] b_dc_addr, b_dc_wdata, b_dc_rdata;

  dmem_port_arbiter #(.STORE_FIRST(SF0), .WDOG_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .rob_mem_write(rob_mem_write), .rob_mem_address(rob_mem_address),
    .rob_mem_wdata(rob_mem_wdata), .rob_mem_byte_enable(rob_mem_byte_enable),
    .rob_mem_resp(rob_mem_resp),
    .ld_mem_read(ld_mem_read), .ld_mem_address(ld_mem_address),
    .ld_mem_resp(ld_mem_resp), .ld_mem_rdata(ld_mem_rdata),
    .flush(flush),
    .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write),
    .dc_mem_address(dc_mem_address), .dc_mem_wdata(dc_mem_wdata),
    .dc_mem_byte_enable(dc_mem_byte_enable), .dc_mem_resp(dc_mem_resp),
    .dc_mem_rdata(dc_mem_rdata), .mem_hang(mem_hang)
  );

  dmem_port_arbiter #(.STORE_FIRST(1'b0)) dut_lf (
    .clk(clk), .rst(rst),
    .rob_mem_write(b_rob_write), .rob_mem_address(b_rob_addr),
    .rob_mem_wdata(b_rob_wdata), .rob_mem_byte_enable(b_rob_be),
    .rob_mem_resp(b_rob_resp),
    .ld_mem_read(b_ld_read), .ld_mem_address(b_ld_addr),
    .ld_mem_resp(b_ld_resp), .ld_mem_rdata(b_ld_rdata),
    .flush(b_flush),
    .dc_mem_read(b_dc_read), .dc_mem_write(b_dc_write),
    .dc_mem_address(b_dc_addr), .dc_mem_wdata(b_dc_wdata),
    .dc_mem_byte_enable(b_dc_be), .dc_mem_resp(b_dc_resp),
    .dc_mem_rdata(b_dc_rdata), .mem_hang(b_hang)
  );

  typedef struct {bit wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int dur;} dc_exp_t;
  typedef struct {bit st; logic [31:0] rdata;} rsp_exp_t;
  typedef struct {int lat; logic [31:0] rdata;} cache_t;

  dc_exp_t dc_q[$];
  rsp_exp_t rsp_q[$];
  cache_t cache_q[$];

  int total = 0;
  int bad = 0;
  bit chk_hang = 1'b1;
  bit idle_noise = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input int lat);
    dc_q.push_back('{1'b1, a, d, be, lat});
    cache_q.push_back('{lat, 32'h0});
    rsp_q.push_back('{1'b1, 32'h0});
  endtask

  task automatic push_ld(input logic [31:0] a, input logic [31:0] rd, input int lat, input bit flushed);
    dc_q.push_back('{1'b0, a & 32'hFFFF_FFFC, 32'h0, 4'hF, lat});
    cache_q.push_back('{lat, rd});
    if (!flushed) rsp_q.push_back('{1'b0, rd});
  endtask

  // Cache model: answers each transaction after its queued latency (0 = never answers).
  initial begin
    int cnt;
    bit in_txn;
    cache_t cur;
    cnt = 0; in_txn = 1'b0; cur = '{0, 32'h0};
    dc_mem_resp = 1'b0; dc_mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      dc_mem_resp = 1'b0;
      dc_mem_rdata = 32'h0;
      if (rst) in_txn = 1'b0;
      else if (dc_mem_read || dc_mem_write) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          cnt = 0;
          if (cache_q.size() > 0) cur = cache_q.pop_front();
          else cur = '{0, 32'h0};
        end
        cnt++;
        if (cur.lat != 0 && cnt == cur.lat) begin
          dc_mem_resp = 1'b1;
          dc_mem_rdata = cur.rdata;
          in_txn = 1'b0;
        end
      end else if (idle_noise && $urandom_range(0, 3) == 0) begin
        dc_mem_resp = 1'b1;
        dc_mem_rdata = $urandom;
      end
    end
  end

  // Monitor: compares each cache transaction and each requester response against the queues.
  initial begin
    bit prev_act, act, have;
    int dur;
    dc_exp_t cur;
    rsp_exp_t e;
    prev_act = 1'b0; have = 1'b0; dur = 0;
    cur = '{1'b0, 32'h0, 32'h0, 4'h0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_act = 1'b0;
        have = 1'b0;
      end else begin
        act = dc_mem_read || dc_mem_write;
        check("rd_wr_exclusive", {31'h0, dc_mem_read & dc_mem_write}, 32'h0);
        if (act && !prev_act) begin
          if (dc_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_dc_txn: got read=%0b write=%0b addr=%h expected none", dc_mem_read, dc_mem_write, dc_mem_address);
          end else begin
            cur = dc_q.pop_front();
            have = 1'b1;
            dur = 0;
            check("dc_write_kind", {31'h0, dc_mem_write}, {31'h0, cur.wr});
            check("dc_address", dc_mem_address, cur.addr);
            check("dc_byte_enable", {28'h0, dc_mem_byte_enable}, {28'h0, cur.be});
            if (cur.wr) check("dc_wdata", dc_mem_wdata, cur.wdata);
          end
        end
        if (act) dur++;
        if (!act && prev_act && have) begin
          if (cur.dur != 0) check("dc_duration", dur, cur.dur);
          have = 1'b0;
        end
        if (rob_mem_resp || ld_mem_resp) begin
          check("resp_one_hot", {31'h0, rob_mem_resp & ld_mem_resp}, 32'h0);
          if (rsp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_resp: got rob=%0b ld=%0b expected none", rob_mem_resp, ld_mem_resp);
          end else begin
            e = rsp_q.pop_front();
            check("resp_kind_store", {31'h0, rob_mem_resp}, {31'h0, e.st});
            if (!e.st) check("ld_rdata", ld_mem_rdata, e.rdata);
          end
        end else begin
          check("ld_rdata_idle_zero", ld_mem_rdata, 32'h0);
        end
        if (chk_hang) check("no_hang", {31'h0, mem_hang}, 32'h0);
        prev_act = act;
      end
    end
  end

  task automatic scenario(input bit do_st, input bit do_ld, input bit ld_first, input int gap,
                          input bit idle_flush, input int st_lat, input int ld_lat,
                          input int st_flush_at, input int ld_flush_at,
                          input logic [31:0] st_addr, input logic [31:0] st_data, input logic [3:0] st_be,
                          input logic [31:0] ld_addr, input logic [31:0] ld_rdata);
    bit first_st, st_drop, ld_drop, st_fin, ld_fin, done;
    int st_t, ld_t, st_cyc, ld_cyc;
    first_st = (do_st && do_ld) ? ((gap == 0) ? (SF0 || idle_flush) : !ld_first) : do_st;
    if (do_st && first_st) push_st(st_addr, st_data, st_be, st_lat);
    if (do_ld) push_ld(ld_addr, ld_rdata, ld_lat, ld_flush_at != 0);
    if (do_st && !first_st) push_st(st_addr, st_data, st_be, st_lat);
    st_t = (gap > 0 && ld_first) ? gap : 0;
    ld_t = (gap > 0 && !ld_first) ? gap : 0;
    st_drop = 0; ld_drop = 0; st_fin = 0; ld_fin = 0; done = 0; st_cyc = 0; ld_cyc = 0;
    @(posedge clk); #2;
    for (int c = 0; c < 80 && !done; c++) begin
      if (c > 0) begin @(posedge clk); #2; end
      flush = 1'b0;
      if (st_drop) begin rob_mem_write = 1'b0; st_drop = 0; st_fin = 1; end
      if (ld_drop) begin ld_mem_read = 1'b0; ld_drop = 0; ld_fin = 1; end
      if (do_st && c == st_t) begin
        rob_mem_write = 1'b1; rob_mem_address = st_addr;
        rob_mem_wdata = st_data; rob_mem_byte_enable = st_be;
      end
      if (do_ld && c == ld_t) begin
        ld_mem_read = 1'b1; ld_mem_address = ld_addr;
      end
      if (idle_flush && c == 0) flush = 1'b1;
      if (idle_flush && c == 1)
        check("idle_flush_grant", {30'h0, dc_mem_read, dc_mem_write}, {30'h0, 1'b0, do_st});
      if (dc_mem_read) begin
        ld_cyc++;
        if (ld_cyc == ld_flush_at) begin flush = 1'b1; ld_mem_read = 1'b0; ld_fin = 1; end
      end
      if (dc_mem_write) begin
        st_cyc++;
        if (st_cyc == st_flush_at) flush = 1'b1;
      end
      if (rob_mem_resp) st_drop = 1;
      if (ld_mem_resp) ld_drop = 1;
      done = (!do_st || st_fin) && (!do_ld || ld_fin) && !dc_mem_read && !dc_mem_write;
    end
    check("scenario_done", {31'h0, done}, 32'h1);
    flush = 1'b0;
  endtask

  initial begin
    bit ds, dl, lf, idf;
    int gp, sl, ll, sfa, lfa;
    int k;
    rst = 1'b1; flush = 1'b0;
    rob_mem_write = 0; rob_mem_address = 0; rob_mem_wdata = 0; rob_mem_byte_enable = 0;
    ld_mem_read = 0; ld_mem_address = 0;
    b_rob_write = 0; b_rob_addr = 0; b_rob_wdata = 0; b_rob_be = 0;
    b_ld_read = 0; b_ld_addr = 0; b_flush = 0; b_dc_resp = 0; b_dc_rdata = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_dc_read", {31'h0, dc_mem_read}, 32'h0);
    check("rst_dc_write", {31'h0, dc_mem_write}, 32'h0);
    check("rst_dc_address", dc_mem_address, 32'h0);
    check("rst_dc_wdata", dc_mem_wdata, 32'h0);
    check("rst_dc_be", {28'h0, dc_mem_byte_enable}, 32'h0);
    check("rst_hang", {31'h0, mem_hang}, 32'h0);
    check("rst_b_dc_addr", b_dc_addr, 32'h0);
    rst = 1'b0;

    // store then already-pending load
    scenario(1, 1, 0, 0, 0, 3, 2, 0, 0, 32'h100, 32'hDEADBEEF, 4'hF, 32'h102, 32'h12345678);
    // simultaneous requests, store priority
    scenario(1, 1, 0, 0, 0, 2, 2, 0, 0, 32'h200, 32'hA1B2C3D4, 4'h3, 32'h300, 32'h0BADCAFE);
    // flush one cycle into the load, cache answers four cycles later
    scenario(0, 1, 0, 0, 0, 1, 5, 0, 1, 32'h0, 32'h0, 4'h0, 32'h404, 32'h55AA55AA);
    // flush in the same cycle as the load response
    scenario(0, 1, 0, 0, 0, 1, 3, 0, 3, 32'h0, 32'h0, 4'h0, 32'h508, 32'h77778888);
    // flush while a store is in flight
    scenario(1, 0, 0, 0, 0, 3, 1, 1, 0, 32'h600, 32'h13579BDF, 4'hC, 32'h0, 32'h0);
    // flush in IDLE blocks the load grant for one cycle
    scenario(0, 1, 0, 0, 1, 1, 2, 0, 0, 32'h0, 32'h0, 4'h0, 32'h70F, 32'h2468ACE0);

    idle_noise = 1'b1;
    for (int n = 0; n < 40; n++) begin
      ds = $urandom_range(0, 1);
      dl = $urandom_range(0, 1);
      if (!ds && !dl) dl = 1;
      lf = $urandom_range(0, 1);
      gp = (ds && dl) ? $urandom_range(0, 3) : 0;
      idf = (gp == 0) && ($urandom_range(0, 4) == 0);
      sl = $urandom_range(1, 6);
      ll = $urandom_range(1, 6);
      sfa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, sl) : 0;
      lfa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ll) : 0;
      scenario(ds, dl, lf, gp, idf, sl, ll, sfa, lfa,
               $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(1, 15)),
               $urandom, $urandom);
    end
    idle_noise = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("dc_q_empty", dc_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);

    // watchdog: cache never answers a load
    chk_hang = 1'b0;
    dc_q.push_back('{1'b0, 32'h40, 32'h0, 4'hF, 0});
    cache_q.push_back('{0, 32'h0});
    ld_mem_read = 1'b1; ld_mem_address = 32'h41;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (dc_mem_read) k++;
      if (k == 8 && dc_mem_read) check("hang_not_yet", {31'h0, mem_hang}, 32'h0);
      if (k == 9 && dc_mem_read) check("hang_set", {31'h0, mem_hang}, 32'h1);
    end
    check("hang_sticky", {31'h0, mem_hang}, 32'h1);
    check("hang_read_held", {31'h0, dc_mem_read}, 32'h1);
    rst = 1'b1;
    ld_mem_read = 1'b0;
    @(posedge clk); #2;
    check("abort_dc_read", {31'h0, dc_mem_read}, 32'h0);
    check("abort_dc_address", dc_mem_address, 32'h0);
    check("abort_dc_be", {28'h0, dc_mem_byte_enable}, 32'h0);
    check("abort_ld_resp", {31'h0, ld_mem_resp}, 32'h0);
    check("abort_rob_resp", {31'h0, rob_mem_resp}, 32'h0);
    check("abort_hang_clear", {31'h0, mem_hang}, 32'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("post_rst_idle", {30'h0, dc_mem_read, dc_mem_write}, 32'h0);
    chk_hang = 1'b1;

    // load-priority instance: simultaneous requests, load first
    b_rob_write = 1; b_rob_addr = 32'h200; b_rob_wdata = 32'h0BADF00D; b_rob_be = 4'hF;
    b_ld_read = 1; b_ld_addr = 32'h300;
    @(posedge clk); #2;
    check("lf_first_read", {30'h0, b_dc_read, b_dc_write}, 32'h2);
    check("lf_first_addr", b_dc_addr, 32'h300);
    b_dc_resp = 1; b_dc_rdata = 32'hCAFE0300;
    #1;
    check("lf_ld_resp", {31'h0, b_ld_resp}, 32'h1);
    check("lf_ld_rdata", b_ld_rdata, 32'hCAFE0300);
    check("lf_rob_quiet", {31'h0, b_rob_resp}, 32'h0);
    @(posedge clk); #2;
    b_dc_resp = 0; b_dc_rdata = 0; b_ld_read = 0;
    check("lf_gap_idle", {30'h0, b_dc_read, b_dc_write}, 32'h0);
    @(posedge clk); #2;
    check("lf_second_write", {30'h0, b_dc_read, b_dc_write}, 32'h1);
    check("lf_second_addr", b_dc_addr, 32'h200);
    check("lf_second_wdata", b_dc_wdata, 32'h0BADF00D);
    b_dc_resp = 1;
    #1;
    check("lf_rob_resp", {31'h0, b_rob_resp}, 32'h1);
    @(posedge clk); #2;
    b_dc_resp = 0; b_rob_write = 0;
    // flush in IDLE blocks the load but the store still goes, even with load priority
    @(posedge clk); #2;
    b_flush = 1; b_rob_write = 1; b_rob_addr = 32'h204; b_ld_read = 1; b_ld_addr = 32'h308;
    @(posedge clk); #2;
    b_flush = 0;
    check("lf_flush_store_wins", {30'h0, b_dc_read, b_dc_write}, 32'h1);
    check("lf_flush_store_addr", b_dc_addr, 32'h204);
    b_dc_resp = 1;
    @(posedge clk); #2;
    b_dc_resp = 0; b_rob_write = 0;
    @(posedge clk); #2;
    check("lf_then_load", {30'h0, b_dc_read, b_dc_write}, 32'h2);
    check("lf_then_load_addr", b_dc_addr, 32'h308);
    b_dc_resp = 1; b_dc_rdata = 32'h31415926;
    #1;
    check("lf_then_load_data", b_ld_rdata, 32'h31415926);
    @(posedge clk); #2;
    b_dc_resp = 0; b_dc_rdata = 0; b_ld_read = 0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
